// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Definitions shared by the UART transmit and receive blocks.  |
// |               Holds the data width, the receiver state encoding and the    |
// |               even-parity helper that is also used by the transmitter.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Receiver state encoding. The values are fixed so that the receiver
    // and any debug logic watching its state agree on the numbers.
    localparam logic [2:0] C_ST_IDLE      = 3'd0;
    localparam logic [2:0] C_ST_START     = 3'd1;
    localparam logic [2:0] C_ST_DATA      = 3'd2;
    localparam logic [2:0] C_ST_PARITY    = 3'd3;
    localparam logic [2:0] C_ST_STOP      = 3'd4;
    localparam logic [2:0] C_ST_WAIT_IDLE = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = C_ST_IDLE,
        ST_START     = C_ST_START,
        ST_DATA      = C_ST_DATA,
        ST_PARITY    = C_ST_PARITY,
        ST_STOP      = C_ST_STOP,
        ST_WAIT_IDLE = C_ST_WAIT_IDLE
    } uart_state_e;

    // Parity bit that makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_sync                                                 |
// | Description : Two-flop synchronizer for the asynchronous serial line.      |
// |               Both flops reset to 1 (line idle) so that reset never looks  |
// |               like a start bit.                                            |
// | Ports       : clk   - clock                                                |
// |               rst_n - asynchronous active-low reset                        |
// |               i_d   - asynchronous input                                   |
// |               o_q   - synchronized output (2 cycles latency)                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx                                                      |
// | Description : UART receiver. 1 start, 8 data bits LSB first, optional even |
// |               parity, 1 stop. Received bytes land in a one-entry holding   |
// |               register with a valid/ack handshake.                         |
// |               Build option: define UART_RX_PARITY_EN to add the parity     |
// |               bit and the parity check; otherwise parity_err is tied low.  |
// | Ports       : clk, rst_n   - clock, asynchronous active-low reset          |
// |               rx           - serial line (idle high, asynchronous)         |
// |               rx_data      - last good byte                                |
// |               rx_valid     - holding register full, held until rx_ack      |
// |               rx_ack       - consumer takes the byte                       |
// |               busy         - receiver not idle                             |
// |               framing_err  - 1-cycle pulse, stop bit sampled low           |
// |               parity_err   - 1-cycle pulse, parity mismatch                |
// |               overrun      - sticky, good byte arrived while full          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ack,
    output logic                   busy,
    output logic                   framing_err,
    output logic                   parity_err,
    output logic                   overrun
);

    localparam int                 C_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int                 C_IDX_W     = $clog2(UART_DATA_W);
    localparam logic [C_CNT_W-1:0] C_HALF_LAST = C_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [C_CNT_W-1:0] C_BIT_LAST  = C_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST  = C_IDX_W'(UART_DATA_W - 1);

    logic                   w_rxs;
    uart_state_e            r_state,  w_state_nxt;
    logic [C_CNT_W-1:0]     r_cnt,    w_cnt_nxt;
    logic [C_IDX_W-1:0]     r_idx,    w_idx_nxt;
    logic [UART_DATA_W-1:0] r_shift,  w_shift_nxt;

    // Stop-bit outcome, registered once so that the holding register and the
    // error pulses update one cycle after the stop sample.
    logic                   r_load_pend, w_load_pend_nxt;
    logic                   r_ferr_pend, w_ferr_pend_nxt;

    logic [UART_DATA_W-1:0] r_data;
    logic                   r_valid;
    logic                   r_overrun;
    logic                   r_framing_err;

`ifdef UART_RX_PARITY_EN
    logic                   r_par_bad,   w_par_bad_nxt;
    logic                   r_perr_pend, w_perr_pend_nxt;
    logic                   r_parity_err;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rxs)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_load_pend <= 1'b0;
            r_ferr_pend <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad   <= 1'b0;
            r_perr_pend <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_load_pend <= w_load_pend_nxt;
            r_ferr_pend <= w_ferr_pend_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad   <= w_par_bad_nxt;
            r_perr_pend <= w_perr_pend_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The counter restarts at 0 on every sample point,
    // so each state only ever compares against a single terminal count.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_shift_nxt     = r_shift;
        w_load_pend_nxt = 1'b0;
        w_ferr_pend_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt   = r_par_bad;
        w_perr_pend_nxt = 1'b0;
`endif

        case (r_state)
            ST_IDLE: begin
                if (!w_rxs) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_START;
`ifdef UART_RX_PARITY_EN
                    w_par_bad_nxt = 1'b0;
`endif
                end
            end

            ST_START: begin
                if (r_cnt == C_HALF_LAST) begin
                    w_cnt_nxt = '0;
                    // A line that is high again at mid start bit was a glitch.
                    w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_rxs;
                    if (r_idx == C_IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + C_IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_nxt     = '0;
                    w_par_bad_nxt = (w_rxs != even_parity(r_shift));
                    w_state_nxt   = ST_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end
`endif

            ST_STOP: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (!w_rxs) begin
                        // Stop low may be a break: wait for the line to
                        // return high before hunting for a start bit.
                        w_ferr_pend_nxt = 1'b1;
                        w_state_nxt     = ST_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                    end else if (r_par_bad) begin
                        w_perr_pend_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
`endif
                    end else begin
                        w_load_pend_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end

            ST_WAIT_IDLE: begin
                if (w_rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register, handshake and error outputs. A load in the same
    // cycle as an ack counts as the old byte being consumed, so it is not
    // an overrun. r_shift is untouched until the next frame's first data
    // sample, so it is still valid during the pending-load cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_overrun     <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            r_framing_err <= r_ferr_pend;
            if (r_load_pend) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                if (r_valid && !rx_ack) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= r_perr_pend;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign overrun     = r_overrun;
    assign framing_err = r_framing_err;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx                                                   |
// | Description : Self-checking bench for uart_rx with CLKS_PER_BIT=10 and a   |
// |               10 ns clock. Frames are built bit by bit; the expected       |
// |               outcome and latency come from the frame format rules.       |
// |               Follows UART_RX_PARITY_EN the same way the RTL does.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_rx;

    localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // Falling edge of rx to the cycle the byte / error becomes visible.
    localparam int LAT = 3 + CPB / 2 + (9 + P) * CPB + 1;

    localparam int K_GOOD = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       framing_err;
    logic       parity_err;
    logic       overrun;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .busy        (busy),
        .framing_err (framing_err),
        .parity_err  (parity_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: sampled on the falling edge, away from the active edge.
    int   valid_rises = 0, valid_cyc = 0;
    int   ferr_hi = 0, ferr_cyc = 0;
    int   perr_hi = 0, perr_cyc = 0;
    int   busy_hi = 0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            valid_rises++;
            valid_cyc = cyc;
        end
        if (framing_err) begin
            ferr_hi++;
            ferr_cyc = cyc;
        end
        if (parity_err) begin
            perr_hi++;
            perr_cyc = cyc;
        end
        if (busy) busy_hi++;
        prev_valid = rx_valid;
    end

    int vecs = 0;
    int errs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Parity bit that gives an even count of ones over data + parity.
    function automatic logic ref_par(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    function automatic int ref_kind(input logic [7:0] d, input logic par, input logic stop);
        if (!stop) return K_FERR;
        if (P == 1 && par != ref_par(d)) return K_PERR;
        return K_GOOD;
    endfunction

    // Call just after a rising edge; each bit lasts CPB cycles.
    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int stop_len);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
        if (P == 1) drive_bit(par, CPB);
        drive_bit(stop, stop_len);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_ack(input string tag);
        rx_ack = 1'b1;
        idle(1);
        rx_ack = 1'b0;
        check(tag, rx_valid, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
    endtask

    int         t0, t1, b_valid, b_ferr, b_perr, b_busy, kind;
    logic [7:0] d;
    logic       par, stop;

    initial begin
        idle(3);
        check("reset_data", rx_data, 8'h00);
        check("reset_valid", rx_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_ferr", framing_err, 1'b0);
        check("reset_perr", parity_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        idle(4);

        // Basic good byte and ack.
        b_valid = valid_rises;
        t0 = cyc;
        send_frame(8'hA5, ref_par(8'hA5), 1'b1, CPB);
        idle(3);
        check("a5_rise", valid_rises - b_valid, 1);
        check("a5_latency", valid_cyc - t0, LAT);
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid", rx_valid, 1'b1);
        do_ack("a5_ack");

        // Short glitch on the line.
        b_valid = valid_rises; b_ferr = ferr_hi; b_perr = perr_hi; b_busy = busy_hi;
        drive_bit(1'b0, 3);
        rx = 1'b1;
        idle(15);
        check("glitch_busy_seen", (busy_hi - b_busy) > 0, 1'b1);
        check("glitch_busy_end", busy, 1'b0);
        check("glitch_no_valid", valid_rises - b_valid, 0);
        check("glitch_no_err", (ferr_hi - b_ferr) + (perr_hi - b_perr), 0);

        // Stop bit held low for 20 cycles.
        b_valid = valid_rises; b_ferr = ferr_hi;
        t0 = cyc;
        send_frame(8'h3C, ref_par(8'h3C), 1'b0, 2 * CPB);
        check("ferr_pulse_width", ferr_hi - b_ferr, 1);
        check("ferr_latency", ferr_cyc - t0, LAT);
        check("ferr_busy_wait", busy, 1'b1);
        idle(5);
        check("ferr_busy_end", busy, 1'b0);
        check("ferr_no_valid", valid_rises - b_valid, 0);

        // Random frames, checked against the frame-rule model.
        for (int i = 0; i < 8; i++) begin
            d    = 8'($urandom_range(0, 255));
            par  = (P == 1 && $urandom_range(0, 3) == 0) ? ~ref_par(d) : ref_par(d);
            stop = ($urandom_range(0, 4) != 0);
            kind = ref_kind(d, par, stop);
            idle($urandom_range(0, 12));
            b_valid = valid_rises; b_ferr = ferr_hi; b_perr = perr_hi;
            t0 = cyc;
            send_frame(d, par, stop, CPB);
            idle(4);
            check("rnd_valid_rise", valid_rises - b_valid, (kind == K_GOOD) ? 1 : 0);
            check("rnd_ferr", ferr_hi - b_ferr, (kind == K_FERR) ? 1 : 0);
            check("rnd_perr", perr_hi - b_perr, (kind == K_PERR) ? 1 : 0);
            if (kind == K_GOOD) begin
                check("rnd_latency", valid_cyc - t0, LAT);
                check("rnd_data", rx_data, d);
                do_ack("rnd_ack");
            end else if (kind == K_FERR) begin
                check("rnd_ferr_latency", ferr_cyc - t0, LAT);
            end else begin
                check("rnd_perr_latency", perr_cyc - t0, LAT);
            end
        end
        check("rnd_no_overrun", overrun, 1'b0);
        idle(5);

        // Back-to-back frames with no ack.
        b_valid = valid_rises;
        t0 = cyc;
        send_frame(8'h11, ref_par(8'h11), 1'b1, CPB);
        send_frame(8'h22, ref_par(8'h22), 1'b1, CPB);
        idle(3);
        check("b2b_first_latency", valid_cyc - t0, LAT);
        check("b2b_data", rx_data, 8'h22);
        check("b2b_valid", rx_valid, 1'b1);
        check("b2b_overrun", overrun, 1'b1);

        // Reset during data bit 4 of 0xFF.
        b_valid = valid_rises;
        fork
            send_frame(8'hFF, ref_par(8'hFF), 1'b1, CPB);
            begin
                idle(5 * CPB + CPB / 2);
                rst_n = 1'b0;
                #1;
                check("rst_data", rx_data, 8'h00);
                check("rst_valid", rx_valid, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_overrun", overrun, 1'b0);
                check("rst_errs", {framing_err, parity_err}, 2'b00);
                idle(3);
                rst_n = 1'b1;
            end
        join
        idle(5);
        check("rst_dropped", valid_rises - b_valid, 0);
        check("rst_idle", busy, 1'b0);
        t0 = cyc;
        send_frame(8'h5A, ref_par(8'h5A), 1'b1, CPB);
        idle(3);
        check("after_rst_latency", valid_cyc - t0, LAT);
        check("after_rst_data", rx_data, 8'h5A);
        do_ack("after_rst_ack");

        // Back-to-back with ack exactly on the second load cycle.
        send_frame(8'h11, ref_par(8'h11), 1'b1, CPB);
        t1 = cyc;
        fork
            send_frame(8'h22, ref_par(8'h22), 1'b1, CPB);
            begin
                idle(LAT - 1);
                rx_ack = 1'b1;
                idle(1);
                rx_ack = 1'b0;
            end
        join
        idle(3);
        check("ackload_data", rx_data, 8'h22);
        check("ackload_valid", rx_valid, 1'b1);
        check("ackload_overrun", overrun, 1'b0);
        do_ack("ackload_ack");

`ifdef UART_RX_PARITY_EN
        b_valid = valid_rises; b_perr = perr_hi;
        t0 = cyc;
        send_frame(8'h07, 1'b0, 1'b1, CPB);
        idle(3);
        check("par_bad_pulse", perr_hi - b_perr, 1);
        check("par_bad_latency", perr_cyc - t0, LAT);
        check("par_bad_no_valid", valid_rises - b_valid, 0);
        t0 = cyc;
        send_frame(8'h07, 1'b1, 1'b1, CPB);
        idle(3);
        check("par_ok_latency", valid_cyc - t0, LAT);
        check("par_ok_data", rx_data, 8'h07);
        do_ack("par_ok_ack");
`else
        check("noparity_tied", perr_hi, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
